isr_pipe_sqrt: RTL
==================

# isr_pipe_sqrt

Parametrised iterative integer square root unit for the project2 arithmetic datapath. It computes floor(sqrt(value)) for an unsigned WIDTH-bit radicand using the restoring digit-by-digit method, so no multiplier is needed. It resolves BITS_PER_CYCLE root bits per clock and uses an explicit start/busy/done handshake. It is the generalised successor to the fixed 64-bit, multiplier-based square-root unit.

## Interface
- WIDTH, 64: radicand width in bits. Must be even and ≥4.
- BITS_PER_CYCLE, 1: root bits resolved per clock. Must divide WIDTH/2. Legal values are 1, 2 and 4.
- clock  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- start  in  1: request a new computation. Sampled on the rising edge.
- value  in  WIDTH: radicand, captured when start is accepted.
- busy  out  1: high while a computation is in progress.
- done  out  1: high while result is valid.
- result  out  WIDTH/2: floor(sqrt(value)).
- remainder  out  WIDTH/2+1: value − result². Present only with ISR_REMAINDER_EN.

## Operation
- STEPS = WIDTH/(2·BITS_PER_CYCLE).
- Internal registers:
  - rad: WIDTH bits, shifted left 2 per digit.
  - rem: WIDTH/2+2 bits.
  - root: WIDTH/2 bits.
  - cnt: $clog2(STEPS)+1 bits.
- State machine:
  - IDLE → CALC on start.
  - CALC → DONE when cnt reaches STEPS.
  - DONE → CALC on start.
  - No other transitions.
- Accepting start (state IDLE or DONE):
  - rad ← value, rem ← 0, root ← 0, cnt ← 0.
  - done drops and busy rises.
- In CALC, BITS_PER_CYCLE digit steps run in chain each cycle. One digit step is:
  - r' = (rem << 2) | rad[WIDTH-1:WIDTH-2]; shift rad left by 2.
  - t = (root << 2) | 1, zero-extended to the rem width.
  - If r' ≥ t (unsigned): rem ← r' − t, root ← (root << 1) | 1.
  - Otherwise: rem ← r', root ← root << 1.
- All arithmetic is unsigned. rem never exceeds 2·root, so WIDTH/2+2 bits cannot overflow.
- Completion: result ← root, done ← 1, busy ← 0. result and done hold until the next accepted start.
- start while busy is ignored. value changes while busy have no effect.
- start asserted in the same cycle as the final CALC step is ignored. A restart is accepted at the earliest from DONE.
- Reset, including mid-computation: the computation is aborted with no residue.
  - State IDLE, busy=0, done=0, result=0.
  - remainder=0 (when enabled), all internal registers cleared.

## Timing
- Start sampled high at edge t0 in IDLE or DONE → busy=1 from t0.
- Digit steps execute on edges t0+1 … t0+STEPS.
- done=1 and result valid from edge t0+STEPS, i.e. a latency of STEPS cycles.
- Back-to-back throughput is one result per STEPS+1 cycles when start is held high.
- Example latencies at WIDTH=64: 32 cycles with BITS_PER_CYCLE=1, 8 cycles with BITS_PER_CYCLE=4.
- Outputs are registered. There is no combinational path from start or value to any output.

## Configuration
- ISR_REMAINDER_EN defined:
  - remainder port exists.
  - It is loaded from rem[WIDTH/2:0] in the same cycle as result and holds with it.
- ISR_REMAINDER_EN undefined:
  - No remainder port.
  - rem is still kept internally, since the algorithm needs it.
  - result and timing are identical to the enabled build.

## Structure
- Shared package isr_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} isr_state_t.
  - Legal BITS_PER_CYCLE values.
  - A function computing STEPS, used in the elaboration-time assertion that WIDTH is even and BITS_PER_CYCLE divides WIDTH/2.
- Sub-module isr_digit_step is purely combinational: one digit step (rem, root, 2 radicand bits in → rem, root out). It is instantiated BITS_PER_CYCLE times in a generate chain.
- The top level holds the FSM, counter and registers.

## Test plan
- WIDTH=64, BPC=1, value=0 → done after exactly 32 cycles, result=0, remainder=0. busy is high for cycles 0–31 after start.
- WIDTH=64, BPC=1, value=0xFFFF_FFFF_FFFF_FFFF → result=0xFFFF_FFFF, remainder=0x1_FFFF_FFFE.
- WIDTH=64, BPC=4: value=1_000_000 → result=1000, remainder=0, done after 8 cycles. value=99 → result=9, remainder=18.
- Start with value=144, then at cycle 5 pulse start with value=4 → second start ignored, result=12. Then start with value=4 from DONE → result=2.
- Assert reset at cycle 10 of a computation → busy, done and result go to 0 immediately (asynchronous). A later start with value=50 → result=7, remainder=1.
- Randomised plus corner values for WIDTH∈{8,16,64} and all legal BPC: result² ≤ value < (result+1)². Build once without ISR_REMAINDER_EN and check results and latency match.

Source files
------------

// File: rtl/isr_pkg.sv
// Shared types and elaboration helpers for the iterative integer square root unit.
// Used by isr_pipe_sqrt (optional remainder output controlled by ISR_REMAINDER_EN).
package isr_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} isr_state_t;

    // Bit n set means BITS_PER_CYCLE == n is supported (1, 2 and 4).
    localparam logic [4:0] ISR_BPC_LEGAL_MASK = 5'b10110;

    function automatic int unsigned isr_steps(input int unsigned width, input int unsigned bpc);
        return width / (2 * bpc);
    endfunction

    function automatic bit isr_bpc_legal(input int unsigned bpc);
        return (bpc < 5) && ISR_BPC_LEGAL_MASK[bpc[2:0]];
    endfunction

    function automatic bit isr_cfg_ok(input int unsigned width, input int unsigned bpc);
        if (width < 4 || (width % 2) != 0 || !isr_bpc_legal(bpc)) begin
            return 1'b0;
        end
        return (isr_steps(width, bpc) * 2 * bpc) == width;
    endfunction

endpackage

// File: rtl/isr_digit_step.sv
// One restoring square-root digit step: brings in two radicand bits and resolves one root bit.
// Purely combinational; chained BITS_PER_CYCLE times inside isr_pipe_sqrt.
module isr_digit_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH/2+1:0] i_rem,
    input  logic [WIDTH/2-1:0] i_root,
    input  logic [1:0]         i_bits,
    output logic [WIDTH/2+1:0] o_rem,
    output logic [WIDTH/2-1:0] o_root
);

    localparam int unsigned HW = WIDTH / 2;
    localparam int unsigned RW = HW + 2;

    logic [RW-1:0] w_r;
    logic [RW-1:0] w_t;
    logic          w_ge;

    // rem stays <= 2*root, so the bits dropped by the shift are always zero.
    assign w_r    = RW'({i_rem, i_bits});
    assign w_t    = {i_root, 2'b01};
    assign w_ge   = (w_r >= w_t);
    assign o_rem  = w_ge ? (w_r - w_t) : w_r;
    assign o_root = {i_root[HW-2:0], w_ge};

endmodule

// File: rtl/isr_pipe_sqrt.sv
// Iterative floor(sqrt(value)) with start/busy/done handshake, BITS_PER_CYCLE root bits per clock.
// Define ISR_REMAINDER_EN to expose o_remainder = value - result^2.
module isr_pipe_sqrt
    import isr_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_value,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH/2-1:0] o_result
`ifdef ISR_REMAINDER_EN
    ,
    output logic [WIDTH/2:0]   o_remainder
`endif
);

    localparam int unsigned HW    = WIDTH / 2;
    localparam int unsigned RW    = HW + 2;
    localparam int unsigned STEPS = isr_steps(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CNT_W = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    if (!isr_cfg_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
        $error("isr_pipe_sqrt: WIDTH must be even and >= 4, BITS_PER_CYCLE in {1,2,4} dividing WIDTH/2");
    end

    isr_state_t       r_state, w_state_d;
    logic [WIDTH-1:0] r_rad, w_rad_d;
    logic [RW-1:0]    r_rem, w_rem_d;
    logic [HW-1:0]    r_root, w_root_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [HW-1:0]    r_result, w_result_d;
`ifdef ISR_REMAINDER_EN
    logic [HW:0]      r_remainder, w_remainder_d;
`endif

    logic [RW-1:0] w_rem_c  [BITS_PER_CYCLE+1];
    logic [HW-1:0] w_root_c [BITS_PER_CYCLE+1];

    assign w_rem_c[0]  = r_rem;
    assign w_root_c[0] = r_root;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        isr_digit_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .i_rem  (w_rem_c[k]),
            .i_root (w_root_c[k]),
            .i_bits (r_rad[WIDTH-1-2*k -: 2]),
            .o_rem  (w_rem_c[k+1]),
            .o_root (w_root_c[k+1])
        );
    end

    always_comb begin
        w_state_d  = r_state;
        w_rad_d    = r_rad;
        w_rem_d    = r_rem;
        w_root_d   = r_root;
        w_cnt_d    = r_cnt;
        w_result_d = r_result;
`ifdef ISR_REMAINDER_EN
        w_remainder_d = r_remainder;
`endif
        unique case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_state_d = CALC;
                    w_rad_d   = i_value;
                    w_rem_d   = '0;
                    w_root_d  = '0;
                    w_cnt_d   = '0;
                end
            end
            CALC: begin
                w_rad_d  = r_rad << (2 * BITS_PER_CYCLE);
                w_rem_d  = w_rem_c[BITS_PER_CYCLE];
                w_root_d = w_root_c[BITS_PER_CYCLE];
                w_cnt_d  = r_cnt + 1'b1;
                // Final chain output goes straight to the result so done lands on edge t0+STEPS.
                if (r_cnt == LAST_CNT) begin
                    w_state_d  = DONE;
                    w_result_d = w_root_c[BITS_PER_CYCLE];
`ifdef ISR_REMAINDER_EN
                    w_remainder_d = w_rem_c[BITS_PER_CYCLE][HW:0];
`endif
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_rad    <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
`ifdef ISR_REMAINDER_EN
            r_remainder <= '0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_rad    <= w_rad_d;
            r_rem    <= w_rem_d;
            r_root   <= w_root_d;
            r_cnt    <= w_cnt_d;
            r_result <= w_result_d;
`ifdef ISR_REMAINDER_EN
            r_remainder <= w_remainder_d;
`endif
        end
    end

    assign o_busy   = (r_state == CALC);
    assign o_done   = (r_state == DONE);
    assign o_result = r_result;
`ifdef ISR_REMAINDER_EN
    assign o_remainder = r_remainder;
`endif

endmodule
